// File: rtl/ps2_pkg.sv
// Shared scan-code set 2 constants, parser states, key map and the event record
// used by the PS/2 scan sequencer and its event FIFO.
package ps2_pkg;

  localparam logic [7:0] SC_EXT        = 8'hE0;
  localparam logic [7:0] SC_BREAK      = 8'hF0;
  localparam logic [7:0] SC_PAUSE      = 8'hE1;
  localparam logic [7:0] SC_BAT_OK     = 8'hAA;
  localparam logic [7:0] SC_ACK        = 8'hFA;
  localparam logic [7:0] SC_ECHO       = 8'hEE;
  localparam logic [7:0] SC_RESEND     = 8'hFE;
  localparam logic [7:0] SC_ERR_LOW    = 8'h00;
  localparam logic [7:0] SC_ERR_HIGH   = 8'hFF;
  localparam logic [7:0] SC_FAKE_SHIFT = 8'h12;

  // Bytes that follow the E1 that opens the pause sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0,
    SKIP_E1
  } ps2_state_t;

  localparam logic [2:0] KEY_UP    = 3'd0;
  localparam logic [2:0] KEY_DOWN  = 3'd1;
  localparam logic [2:0] KEY_LEFT  = 3'd2;
  localparam logic [2:0] KEY_RIGHT = 3'd3;
  localparam logic [2:0] KEY_SPACE = 3'd4;
  localparam logic [2:0] KEY_ENTER = 3'd5;
  localparam logic [2:0] KEY_ESC   = 3'd6;
  localparam logic [2:0] KEY_W     = 3'd7;

  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;
  localparam logic [7:0] CODE_LEFT  = 8'h6B;
  localparam logic [7:0] CODE_RIGHT = 8'h74;
  localparam logic [7:0] CODE_SPACE = 8'h29;
  localparam logic [7:0] CODE_ENTER = 8'h5A;
  localparam logic [7:0] CODE_ESC   = 8'h76;
  localparam logic [7:0] CODE_W     = 8'h1D;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  function automatic logic is_control(input logic [7:0] b);
    return b inside {SC_BAT_OK, SC_ACK, SC_ECHO, SC_RESEND, SC_ERR_LOW, SC_ERR_HIGH};
  endfunction

  // Returns {hit, held-bit index}; the extended flag is part of the match
  function automatic logic [3:0] key_lookup(input logic ext, input logic [7:0] code);
    logic [3:0] r;
    r = '0;
    case ({ext, code})
      {1'b1, CODE_UP}:    r = {1'b1, KEY_UP};
      {1'b1, CODE_DOWN}:  r = {1'b1, KEY_DOWN};
      {1'b1, CODE_LEFT}:  r = {1'b1, KEY_LEFT};
      {1'b1, CODE_RIGHT}: r = {1'b1, KEY_RIGHT};
      {1'b0, CODE_SPACE}: r = {1'b1, KEY_SPACE};
      {1'b0, CODE_ENTER}: r = {1'b1, KEY_ENTER};
      {1'b0, CODE_ESC}:   r = {1'b1, KEY_ESC};
      {1'b0, CODE_W}:     r = {1'b1, KEY_W};
      default:            r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_scan_sequencer_fifo.sv
// First-word-fall-through FIFO of 10-bit key events; a push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle, otherwise dropped.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  ps2_event_t push_data,
  output logic       full,
  input  logic       pop,
  output logic       valid,
  output ps2_event_t head,
  output logic       drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int FULL_COUNT_INT = DEPTH;
  localparam logic [PTR_W:0] FULL_COUNT = FULL_COUNT_INT[PTR_W:0];

  ps2_event_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_sequencer.sv
// Turns the raw PS/2 byte stream into complete key events, queues them for the
// game logic and tracks which of the eight game keys are currently held.
module ps2_scan_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int PREFIX_TIMEOUT  = 500000,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic [7:0] key_held,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int TMO_W = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PREFIX_TIMEOUT - 1);

  ps2_state_t state, state_next;
  logic [2:0]       skip_cnt, skip_next;
  logic [TMO_W-1:0] tmo_cnt, tmo_next;
  logic             emit;
  ps2_event_t       emit_evt;
  logic             pend_valid;
  ps2_event_t       pend_evt;
  logic [3:0]       lookup;
  logic             is_repeat;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_drop;
  ps2_event_t       head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      skip_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
      tmo_cnt  <= tmo_next;
    end
  end

  // Received bytes take priority over the idle timeout in the same cycle
  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    tmo_next   = tmo_cnt;
    emit       = 1'b0;
    emit_evt   = '0;
    if (rx_valid) begin
      tmo_next = '0;
      if (state == SKIP_E1) begin
        skip_next = skip_cnt - 1'b1;
        if (skip_cnt <= 3'd1) state_next = IDLE;
      end else if (is_control(rx_data)) begin
        state_next = IDLE;
      end else begin
        emit_evt.code = rx_data;
        case (state)
          IDLE: begin
            if (rx_data == SC_EXT) begin
              state_next = GOT_E0;
            end else if (rx_data == SC_BREAK) begin
              state_next = GOT_F0;
            end else if (rx_data == SC_PAUSE) begin
              state_next = SKIP_E1;
              skip_next  = PAUSE_SKIP;
            end else begin
              emit = 1'b1;
            end
          end
          GOT_E0: begin
            if (rx_data == SC_BREAK) begin
              state_next = GOT_E0F0;
            end else begin
              state_next   = IDLE;
              emit         = (rx_data != SC_FAKE_SHIFT);
              emit_evt.ext = 1'b1;
            end
          end
          GOT_F0: begin
            state_next   = IDLE;
            emit         = 1'b1;
            emit_evt.brk = 1'b1;
          end
          GOT_E0F0: begin
            state_next   = IDLE;
            emit         = (rx_data != SC_FAKE_SHIFT);
            emit_evt.ext = 1'b1;
            emit_evt.brk = 1'b1;
          end
          default: state_next = IDLE;
        endcase
      end
    end else if (state != IDLE) begin
      if (tmo_cnt == TMO_LAST) begin
        state_next = IDLE;
        tmo_next   = '0;
      end else begin
        tmo_next = tmo_cnt + 1'b1;
      end
    end
  end

  assign lookup    = key_lookup(pend_evt.ext, pend_evt.code);
  assign is_repeat = (SUPPRESS_REPEAT != 0) && lookup[3] && !pend_evt.brk && key_held[lookup[2:0]];
  assign fifo_push = pend_valid && !is_repeat;

  // One register stage between the parser and the FIFO / held bitmap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_evt   <= '0;
      key_held   <= '0;
    end else begin
      pend_valid <= emit;
      pend_evt   <= emit_evt;
      if (pend_valid && lookup[3]) key_held[lookup[2:0]] <= !pend_evt.brk;
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(pend_evt),
    .full     (fifo_full),
    .pop      (evt_ready),
    .valid    (evt_valid),
    .head     (head),
    .drop     (fifo_drop)
  );

  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_break = head.brk;

  // A drop in the same cycle as a clear leaves the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (fifo_drop && fifo_full) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed bench for ps2_scan_sequencer: a table of byte sequences with
// hand-computed events plus sequences for latency, overflow, timeout and reset.
module tb_ps2_scan_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [7:0] key_held;
  logic       overflow;
  logic       clr_overflow;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct packed {
    logic [63:0] bytes;
    logic [3:0]  nbytes;
    logic        exp_valid;
    logic [7:0]  exp_code;
    logic        exp_ext;
    logic        exp_brk;
    logic [7:0]  exp_held;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  ps2_scan_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .PREFIX_TIMEOUT (TMO),
    .SUPPRESS_REPEAT(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_code    (evt_code),
    .evt_ext     (evt_ext),
    .evt_break   (evt_break),
    .key_held    (key_held),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [63:0] b, input int n, input logic v,
                              input logic [7:0] c, input logic e, input logic k,
                              input logic [7:0] h);
    vec_t r;
    r.bytes     = b;
    r.nbytes    = 4'(n);
    r.exp_valid = v;
    r.exp_code  = c;
    r.exp_ext   = e;
    r.exp_brk   = k;
    r.exp_held  = h;
    return r;
  endfunction

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_event(input string name, input logic [7:0] code, input logic ext, input logic brk);
    check_output({name, "_valid"}, 16'(evt_valid), 16'd1);
    check_output({name, "_code"},  16'(evt_code), 16'(code));
    check_output({name, "_ext"},   16'(evt_ext), 16'(ext));
    check_output({name, "_brk"},   16'(evt_break), 16'(brk));
  endtask

  // Called on a falling edge; the byte is sampled at the following rising edge
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < DEPTH + 2 && evt_valid; i++) pop_one();
    check_output({name, "_drained"}, 16'(evt_valid), 16'd0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    for (int i = 0; i < int'(v.nbytes); i++)
      send_byte(v.bytes[8*(int'(v.nbytes) - 1 - i) +: 8]);
    @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    evt_ready    = 1'b0;
    clr_overflow = 1'b0;

    vecs[0]  = mk(64'h29,               1, 1'b1, 8'h29, 1'b0, 1'b0, 8'h10);
    vecs[1]  = mk(64'hF029,             2, 1'b1, 8'h29, 1'b0, 1'b1, 8'h00);
    vecs[2]  = mk(64'hE075,             2, 1'b1, 8'h75, 1'b1, 1'b0, 8'h01);
    vecs[3]  = mk(64'hE0F075,           3, 1'b1, 8'h75, 1'b1, 1'b1, 8'h00);
    vecs[4]  = mk(64'h75,               1, 1'b1, 8'h75, 1'b0, 1'b0, 8'h00);
    vecs[5]  = mk(64'hF075,             2, 1'b1, 8'h75, 1'b0, 1'b1, 8'h00);
    vecs[6]  = mk(64'hE11477E1F014F077, 8, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    vecs[7]  = mk(64'h1D,               1, 1'b1, 8'h1D, 1'b0, 1'b0, 8'h80);
    vecs[8]  = mk(64'h1D,               1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h80);
    vecs[9]  = mk(64'hE012,             2, 1'b0, 8'h00, 1'b0, 1'b0, 8'h80);
    vecs[10] = mk(64'hE0AA,             2, 1'b0, 8'h00, 1'b0, 1'b0, 8'h80);
    vecs[11] = mk(64'hF01D,             2, 1'b1, 8'h1D, 1'b0, 1'b1, 8'h00);
    vecs[12] = mk(64'hE06B,             2, 1'b1, 8'h6B, 1'b1, 1'b0, 8'h04);
    vecs[13] = mk(64'hE0F06B,           3, 1'b1, 8'h6B, 1'b1, 1'b1, 8'h00);
    vecs[14] = mk(64'h5A,               1, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h20);
    vecs[15] = mk(64'hF05A,             2, 1'b1, 8'h5A, 1'b0, 1'b1, 8'h00);
    vecs[16] = mk(64'hE0F012,           3, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    vecs[17] = mk(64'hF0FA,             2, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    repeat (2) @(negedge clk);
    check_output("rst_valid",    16'(evt_valid), 16'd0);
    check_output("rst_code",     16'(evt_code),  16'd0);
    check_output("rst_ext",      16'(evt_ext),   16'd0);
    check_output("rst_brk",      16'(evt_break), 16'd0);
    check_output("rst_held",     16'(key_held),  16'd0);
    check_output("rst_overflow", 16'(overflow),  16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NVEC; v++) begin
      apply_stimulus(vecs[v]);
      if (vecs[v].exp_valid)
        check_event($sformatf("vec%0d", v), vecs[v].exp_code, vecs[v].exp_ext, vecs[v].exp_brk);
      else
        check_output($sformatf("vec%0d_none", v), 16'(evt_valid), 16'd0);
      check_output($sformatf("vec%0d_held", v), 16'(key_held), 16'(vecs[v].exp_held));
      drain($sformatf("vec%0d", v));
    end

    // Latency: nothing visible right after the completing edge, visible one edge later
    send_byte(8'h76);
    check_output("lat_valid_early", 16'(evt_valid), 16'd0);
    check_output("lat_held_early",  16'(key_held),  16'd0);
    @(negedge clk);
    check_event("lat", 8'h76, 1'b0, 1'b0);
    check_output("lat_held", 16'(key_held), 16'h40);
    drain("lat");
    send_byte(8'hF0);
    send_byte(8'h76);
    @(negedge clk);
    drain("lat_rel");
    check_output("lat_held_rel", 16'(key_held), 16'h00);

    // Overflow: five makes into a depth-4 FIFO
    send_byte(8'h15);
    send_byte(8'h16);
    send_byte(8'h1C);
    send_byte(8'h1B);
    send_byte(8'h23);
    @(negedge clk);
    check_output("ovf_set", 16'(overflow), 16'd1);
    check_event("ovf_head", 8'h15, 1'b0, 1'b0);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check_output("ovf_clr", 16'(overflow), 16'd0);
    send_byte(8'h24);
    pop_one();
    check_output("ovf_pushpop", 16'(overflow), 16'd0);
    check_event("ovf_pushpop_head", 8'h16, 1'b0, 1'b0);
    send_byte(8'h2B);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check_output("ovf_set_wins", 16'(overflow), 16'd1);
    check_event("ovf_q0", 8'h16, 1'b0, 1'b0);
    pop_one();
    check_event("ovf_q1", 8'h1C, 1'b0, 1'b0);
    pop_one();
    check_event("ovf_q2", 8'h1B, 1'b0, 1'b0);
    pop_one();
    check_event("ovf_q3", 8'h24, 1'b0, 1'b0);
    pop_one();
    check_output("ovf_empty", 16'(evt_valid), 16'd0);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;

    // Timeout: a full gap abandons the E0, a gap one cycle short keeps it
    send_byte(8'hE0);
    repeat (TMO) @(negedge clk);
    send_byte(8'h6B);
    @(negedge clk);
    check_event("tmo_expired", 8'h6B, 1'b0, 1'b0);
    check_output("tmo_expired_held", 16'(key_held), 16'h00);
    drain("tmo_expired");
    send_byte(8'hE0);
    repeat (TMO - 1) @(negedge clk);
    send_byte(8'h6B);
    @(negedge clk);
    check_event("tmo_kept", 8'h6B, 1'b1, 1'b0);
    check_output("tmo_kept_held", 16'(key_held), 16'h04);
    drain("tmo_kept");
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    @(negedge clk);
    drain("tmo_rel");
    check_output("tmo_rel_held", 16'(key_held), 16'h00);

    // Reset in GOT_F0 with three events queued
    send_byte(8'h15);
    send_byte(8'h16);
    send_byte(8'h29);
    @(negedge clk);
    check_output("rst2_held_pre", 16'(key_held), 16'h10);
    send_byte(8'hF0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst2_valid",    16'(evt_valid), 16'd0);
    check_output("rst2_held",     16'(key_held),  16'd0);
    check_output("rst2_code",     16'(evt_code),  16'd0);
    check_output("rst2_overflow", 16'(overflow),  16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h29);
    @(negedge clk);
    check_event("rst2_after", 8'h29, 1'b0, 1'b0);
    check_output("rst2_after_held", 16'(key_held), 16'h10);
    drain("rst2_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
